// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the HI/LO pair: one result bit per cycle,
// a single sign-fixup cycle, and MTHI/MTLO writes while idle.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [WIDTH-1:0] mag_a, mag_a_nxt;
    logic [WIDTH-1:0] mag_b, mag_b_nxt;
    logic             sgn_a, sgn_a_nxt;
    logic             sgn_b, sgn_b_nxt;
    logic [AW-1:0]    acc, acc_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             done_nxt;
    logic             busy_nxt;

    // divide datapath temporaries
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [AW-1:0]    prod_fix;

    // State register plus all datapath/output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            mag_a <= '0;
            mag_b <= '0;
            sgn_a <= 1'b0;
            sgn_b <= 1'b0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            mag_a <= mag_a_nxt;
            mag_b <= mag_b_nxt;
            sgn_a <= sgn_a_nxt;
            sgn_b <= sgn_b_nxt;
            acc   <= acc_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state, iteration step and result fixup
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        mag_a_nxt = mag_a;
        mag_b_nxt = mag_b;
        sgn_a_nxt = sgn_a;
        sgn_b_nxt = sgn_b;
        acc_nxt   = acc;
        hi_nxt    = hi;
        lo_nxt    = lo;
        done_nxt  = 1'b0;
        trial     = '0;
        diff      = '0;
        quo_fix   = '0;
        rem_fix   = '0;
        prod_fix  = '0;

        case (state)
            S_IDLE: begin
                if (hi_we) hi_nxt = wdata;
                if (lo_we) lo_nxt = wdata;
                if (start && !abort) begin
                    // op[0]==0 selects the signed variants
                    op_nxt    = op;
                    sgn_a_nxt = ~op[0] & a[WIDTH-1];
                    sgn_b_nxt = ~op[0] & b[WIDTH-1];
                    mag_a_nxt = (~op[0] & a[WIDTH-1]) ? WIDTH'(-a) : a;
                    mag_b_nxt = (~op[0] & b[WIDTH-1]) ? WIDTH'(-b) : b;
                    acc_nxt   = '0;
                    cnt_nxt   = CW'(WIDTH - 1);
                    state_nxt = S_CALC;
                end
            end

            S_CALC: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        // restoring divide: remainder in upper half, quotient shifts into lower half
                        trial = {acc[AW-1:WIDTH], mag_a[cnt]};
                        diff  = trial - {1'b0, mag_b};
                        if (trial >= {1'b0, mag_b}) begin
                            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // MSB-first shift-add over the full-width product
                        acc_nxt = {acc[AW-2:0], 1'b0}
                                + (mag_b[cnt] ? {{WIDTH{1'b0}}, mag_a} : {AW{1'b0}});
                    end
                    if (cnt == '0) begin
                        state_nxt = S_FIX;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end

            S_FIX: begin
                state_nxt = S_IDLE;
                if (!abort) begin
                    done_nxt = 1'b1;
                    if (op_q[1]) begin
                        if (mag_b == '0) begin
                            // divide by zero returns the dividend bits exactly as issued
                            lo_nxt = {WIDTH{1'b1}};
                            hi_nxt = sgn_a ? WIDTH'(-mag_a) : mag_a;
                        end else begin
                            quo_fix = (sgn_a ^ sgn_b) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                            rem_fix = sgn_a ? WIDTH'(-acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
                            lo_nxt  = quo_fix;
                            hi_nxt  = rem_fix;
                        end
                    end else begin
                        prod_fix = (sgn_a ^ sgn_b) ? AW'(-acc) : acc;
                        hi_nxt   = prod_fix[AW-1:WIDTH];
                        lo_nxt   = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: results modelled with 64-bit arithmetic.
module tb_muldiv_seq;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          abort;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   n_vec;
    int unsigned   n_err;
    logic [63:0]   sb_q[$];
    int            poke;
    logic [W-1:0]  lo_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                          input logic [W-1:0] mb);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'h0, ma};
        ub = {32'h0, mb};
        case (mop)
            2'b00: model = 64'(sa * sb);
            2'b01: model = ua * ub;
            2'b10: begin
                if (mb == '0) model = {ma, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (mb == '0) model = {ma, 32'hFFFF_FFFF};
                else model = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Drive one issue cycle; returns #1 after the sampling edge (first busy cycle)
    task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        sb_q.push_back(model(iop, ia, ib));
        @(posedge clk); #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait for done, check latency, busy width and the scoreboard result
    task automatic wait_done(input string tag);
        int cyc;
        int bsy;
        logic [63:0] exp;
        cyc = 1;
        bsy = 0;
        while (!done && cyc < 60) begin
            if (busy) bsy++;
            if (poke == 1 && cyc == 5) begin
                start = 1'b1; op = 2'b11; a = $urandom; b = 32'd1;
            end
            if (poke == 2 && cyc == 8) begin
                lo_we = 1'b1; wdata = 32'hDEAD_BEEF; lo_prev = lo;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            lo_we = 1'b0;
            if (poke == 2 && cyc == 9) check({tag, "_mtlo_busy"}, 64'(lo), 64'(lo_prev));
        end
        check({tag, "_latency"}, 64'(cyc), 64'(W + 2));
        check({tag, "_busy_cycles"}, 64'(bsy), 64'(W + 1));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, exp);
        end
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        poke = 0;
    endtask

    initial begin
        logic [63:0] prev;
        logic        seen;
        n_vec = 0;
        n_err = 0;
        poke  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        abort = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max");
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg");
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg");
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'b11, 32'd7, 32'd2);
        wait_done("divu");
        check("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);
        issue(2'b11, 32'h1234, 32'd0);
        wait_done("divu_zero");
        check("divu_zero_const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf");
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done("div_zero_neg");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin");

        // MTHI in idle, MTLO while busy
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        prev = {hi, lo};
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_idle", {hi, lo}, {32'h0000_AAAA, prev[31:0]});
        poke = 2;
        issue(2'b01, 32'd12345, 32'd678);
        wait_done("mtlo_during_op");

        // Start while busy must be ignored
        poke = 1;
        issue(2'b00, 32'hFFFF_0001, 32'h0000_7FFF);
        wait_done("start_while_busy");

        // Same-cycle MTHI and start: write lands now, result overwrites later
        hi_we = 1'b1; wdata = 32'h5555_5555;
        issue(2'b11, 32'd1000, 32'd7);
        check("mthi_with_start", 64'(hi), 64'h5555_5555);
        wait_done("mthi_then_op");

        // Abort in idle blocks start
        abort = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_idle_block", 64'(busy), 64'd0);

        // Abort at CALC cycle 10
        prev = {hi, lo};
        issue(2'b01, 32'hDEAD_0000, 32'h0000_BEEF);
        void'(sb_q.pop_back());
        repeat (9) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy_drop", 64'(busy), 64'd0);
        check("abort_hilo_keep", {hi, lo}, prev);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // Random operations
        for (int i = 0; i < 12; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issue(rop, ra, rb);
            wait_done($sformatf("rand%0d_op%0d", i, rop));
        end

        // Async reset in the middle of CALC
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0003);
        void'(sb_q.pop_back());
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_hilo", {hi, lo}, 64'd0);
        check("reset_mid_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_idle", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
